// File: rtl/compare_seq_ctrl_pkg.sv
// Shared definitions for the sliced magnitude comparator sequencer.
// Contents: FSM state encoding, one-hot result codes (bit0=EQ, bit1=GT, bit2=LT),
// and a helper that turns the sticky difference flags into a result code.
package compare_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned RES_W = 3;

    localparam logic [RES_W-1:0] RES_EQ = 3'b001;
    localparam logic [RES_W-1:0] RES_GT = 3'b010;
    localparam logic [RES_W-1:0] RES_LT = 3'b100;

    // No difference seen means the operands are equal.
    function automatic logic [RES_W-1:0] res_code(input logic gt, input logic lt);
        if (gt) begin
            return RES_GT;
        end else if (lt) begin
            return RES_LT;
        end
        return RES_EQ;
    endfunction

endpackage

// File: rtl/compare_seq_ctrl_slice.sv
// Combinational unsigned compare of one SLICE-bit operand slice.
// Ports: a_i, b_i (slice operands) -> eq_o, gt_o, lt_o (exactly one high).
module compare_seq_ctrl_slice #(
    parameter int unsigned SLICE = 4
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    output logic             eq_o,
    output logic             gt_o,
    output logic             lt_o
);

    assign eq_o = (a_i == b_i);
    assign gt_o = (a_i > b_i);
    assign lt_o = (a_i < b_i);

endmodule

// File: rtl/compare_seq_ctrl.sv
// Sequencer for a sliced magnitude comparator: accepts an operand pair, compares it
// SLICE bits per cycle MSB slice first on one shared slice comparator, and returns a
// registered one-hot EQ/GT/LT result over a valid/ready handshake.
// Config macro: COMPARE_EARLY_EXIT_EN -- finish on the first unequal slice.
// Ports:
//   SYSCLK, NSYSRESET            clock, synchronous active-low reset
//   start_valid/start_ready      operand handshake, DataA/DataB sampled on accept
//   res_valid/res_ready          result handshake, QAEB/QAGB/QASB valid while res_valid
//   busy                         high while scanning or holding a result
module compare_seq_ctrl
    import compare_seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SLICE = 4
) (
    input  logic             SYSCLK,
    input  logic             NSYSRESET,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] DataA,
    input  logic [WIDTH-1:0] DataB,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             QAEB,
    output logic             QAGB,
    output logic             QASB,
    output logic             busy
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if (SLICE == 0 || WIDTH == 0 || (WIDTH % SLICE) != 0) begin : g_bad_param
        $error("compare_seq_ctrl: WIDTH must be a nonzero multiple of SLICE");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               gt_q, gt_d;
    logic               lt_q, lt_d;
    logic               start_ready_q, start_ready_d;
    logic               res_valid_q, res_valid_d;
    logic               busy_q, busy_d;
    logic [RES_W-1:0]   res_q, res_d;

    logic [SLICE-1:0]   a_sl, b_sl;
    logic               sl_eq, sl_gt, sl_lt;

    // Select the slice currently addressed by idx.
    assign a_sl = SLICE'(a_q >> (32'(idx_q) * SLICE));
    assign b_sl = SLICE'(b_q >> (32'(idx_q) * SLICE));

    compare_seq_ctrl_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a_i  (a_sl),
        .b_i  (b_sl),
        .eq_o (sl_eq),
        .gt_o (sl_gt),
        .lt_o (sl_lt)
    );

    // State and output registers.
    always_ff @(posedge SYSCLK) begin
        if (!NSYSRESET) begin
            state_q       <= ST_IDLE;
            a_q           <= '0;
            b_q           <= '0;
            idx_q         <= '0;
            gt_q          <= 1'b0;
            lt_q          <= 1'b0;
            start_ready_q <= 1'b0;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            res_q         <= '0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            idx_q         <= idx_d;
            gt_q          <= gt_d;
            lt_q          <= lt_d;
            start_ready_q <= start_ready_d;
            res_valid_q   <= res_valid_d;
            busy_q        <= busy_d;
            res_q         <= res_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        idx_d         = idx_q;
        gt_d          = gt_q;
        lt_d          = lt_q;
        start_ready_d = 1'b0;
        res_valid_d   = 1'b0;
        busy_d        = 1'b0;
        res_d         = '0;

        case (state_q)
            ST_IDLE: begin
                if (start_valid && start_ready_q) begin
                    state_d = ST_SCAN;
                    a_d     = DataA;
                    b_d     = DataB;
                    idx_d   = IDX_W'(NSLICE - 1);
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                end
            end
            ST_SCAN: begin
                // The first unequal slice decides; later slices cannot override it.
                if (!gt_q && !lt_q && !sl_eq) begin
                    gt_d = sl_gt;
                    lt_d = sl_lt;
`ifdef COMPARE_EARLY_EXIT_EN
                    state_d = ST_DONE;
`endif
                end
                if (idx_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (res_valid_q && res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered copies of what the next state presents.
        start_ready_d = (state_d == ST_IDLE);
        busy_d        = (state_d != ST_IDLE);
        res_valid_d   = (state_d == ST_DONE);
        res_d         = (state_d == ST_DONE) ? res_code(gt_d, lt_d) : '0;
    end

    assign start_ready = start_ready_q;
    assign res_valid   = res_valid_q;
    assign busy        = busy_q;
    assign QAEB        = res_q[0];
    assign QAGB        = res_q[1];
    assign QASB        = res_q[2];

endmodule

// File: tb/tb_compare_seq_ctrl.sv
// Directed self-checking bench for compare_seq_ctrl with an 8-bit and a 16-bit instance.
// Observed output vector layout: {busy, start_ready, res_valid, QASB, QAGB, QAEB}.
module tb_compare_seq_ctrl;

`ifdef COMPARE_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    localparam logic [2:0] R_EQ = 3'b001;
    localparam logic [2:0] R_GT = 3'b010;
    localparam logic [2:0] R_LT = 3'b100;

    logic        clk = 1'b0;
    logic        NSYSRESET;

    logic        sv8, rr8, srdy8, rv8, eq8, gt8, lt8, busy8;
    logic [7:0]  da8, db8;
    logic        sv16, rr16, srdy16, rv16, eq16, gt16, lt16, busy16;
    logic [15:0] da16, db16;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    compare_seq_ctrl #(.WIDTH(8), .SLICE(4)) u_dut8 (
        .SYSCLK      (clk),
        .NSYSRESET   (NSYSRESET),
        .start_valid (sv8),
        .start_ready (srdy8),
        .DataA       (da8),
        .DataB       (db8),
        .res_valid   (rv8),
        .res_ready   (rr8),
        .QAEB        (eq8),
        .QAGB        (gt8),
        .QASB        (lt8),
        .busy        (busy8)
    );

    compare_seq_ctrl #(.WIDTH(16), .SLICE(4)) u_dut16 (
        .SYSCLK      (clk),
        .NSYSRESET   (NSYSRESET),
        .start_valid (sv16),
        .start_ready (srdy16),
        .DataA       (da16),
        .DataB       (db16),
        .res_valid   (rv16),
        .res_ready   (rr16),
        .QAEB        (eq16),
        .QAGB        (gt16),
        .QASB        (lt16),
        .busy        (busy16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] outs(input logic w);
        if (w) return {busy16, srdy16, rv16, lt16, gt16, eq16};
        return {busy8, srdy8, rv8, lt8, gt8, eq8};
    endfunction

    task automatic drive(input logic w, input logic v, input logic [15:0] a, input logic [15:0] b);
        if (w) begin
            sv16 = v; da16 = a; db16 = b;
        end else begin
            sv8 = v; da8 = a[7:0]; db8 = b[7:0];
        end
    endtask

    // Offer one operand pair in the current cycle (cycle 0) and check the result.
    // With hold set, return in the first result cycle without completing the handshake.
    task automatic run_op(input logic w, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] exp_res, input int exp_lat, input bit hold,
                          input string tag);
        logic [5:0] o;
        int lat;
        drive(w, 1'b1, a, b);
        o = outs(w);
        chk({tag, "/srdy_c0"}, 32'(o[4]), 32'd1);
        tick();
        // Scrambled data after accept must not affect the result.
        drive(w, 1'b0, ~a, ~b);
        o = outs(w);
        chk({tag, "/scan_c1"}, 32'({o[5], o[4], o[2:0]}), 32'b10000);
        lat = 1;
        while (o[3] == 1'b0 && lat < 20) begin
            tick();
            lat++;
            o = outs(w);
        end
        chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "/result"}, 32'(o), 32'({3'b101, exp_res}));
        if (!hold) begin
            tick();
            o = outs(w);
            chk({tag, "/after"}, 32'(o), 32'b010000);
        end
    endtask

    initial begin
        logic [5:0] o;
        NSYSRESET = 1'b0;
        rr8 = 1'b1; rr16 = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 16'h0, 16'h0);
        tick();
        tick();
        chk("reset8", 32'(outs(1'b0)), 32'd0);
        chk("reset16", 32'(outs(1'b1)), 32'd0);
        NSYSRESET = 1'b1;
        tick();
        chk("release8", 32'(outs(1'b0)), 32'b010000);
        chk("release16", 32'(outs(1'b1)), 32'b010000);

        // 8-bit directed vectors
        run_op(1'b0, 16'h35, 16'h35, R_EQ, 3, 1'b0, "eq_35");
        run_op(1'b0, 16'h92, 16'h3F, R_GT, EE ? 2 : 3, 1'b0, "gt_92_3f");
        run_op(1'b0, 16'h47, 16'h4A, R_LT, 3, 1'b0, "lt_47_4a");
        run_op(1'b0, 16'h00, 16'hFF, R_LT, EE ? 2 : 3, 1'b0, "lt_00_ff");
        run_op(1'b0, 16'h0F, 16'h0E, R_GT, 3, 1'b0, "gt_0f_0e");

        // Backpressure: result held, new offers ignored until handshake
        rr8 = 1'b0;
        run_op(1'b0, 16'h10, 16'h20, R_LT, EE ? 2 : 3, 1'b1, "bp");
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 16'hFF, 16'h00);
            tick();
            chk("bp_hold", 32'(outs(1'b0)), 32'b101100);
        end
        rr8 = 1'b1;
        tick();
        chk("bp_taken", 32'(outs(1'b0)), 32'b010000);
        run_op(1'b0, 16'hFF, 16'h00, R_GT, EE ? 2 : 3, 1'b0, "bp_next");

        // Reset during SCAN aborts the operation
        drive(1'b0, 1'b1, 16'h92, 16'h3F);
        tick();
        drive(1'b0, 1'b0, 16'h00, 16'h00);
        NSYSRESET = 1'b0;
        tick();
        chk("rst_mid", 32'(outs(1'b0)), 32'd0);
        NSYSRESET = 1'b1;
        tick();
        chk("rst_rel", 32'(outs(1'b0)), 32'b010000);
        for (int i = 0; i < 4; i++) begin
            tick();
            o = outs(1'b0);
            chk("rst_nores", 32'(o), 32'b010000);
        end
        run_op(1'b0, 16'h0F, 16'h0E, R_GT, 3, 1'b0, "post_rst");

        // 16-bit directed vectors
        run_op(1'b1, 16'h1234, 16'h1235, R_LT, 5, 1'b0, "w16_lt");
        run_op(1'b1, 16'h8000, 16'h7FFF, R_GT, EE ? 2 : 5, 1'b0, "w16_gt");
        run_op(1'b1, 16'hABCD, 16'hABCD, R_EQ, 5, 1'b0, "w16_eq");
        run_op(1'b1, 16'h00F0, 16'h0F00, R_LT, EE ? 3 : 5, 1'b0, "w16_lt2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
